// File: rtl/rom_fetch_ctrl.sv
// Read-request front end for a registered ROM: grants host reads, tracks the
// one-cycle ROM latency and returns responses in order through a 2-entry FIFO.
module rom_fetch_ctrl #(
  parameter  int Width = 32,
  parameter  int Depth = 2048,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              host_req_i,
  input  logic [Aw-1:0]     host_addr_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [Width-1:0]  host_rdata_o,
  output logic              host_rerr_o,
  input  logic              host_rready_i,
  output logic              rom_req_o,
  output logic [Aw-1:0]     rom_addr_o,
  input  logic [Width-1:0]  rom_rdata_i
);

  typedef struct packed {
    logic [Width-1:0] data;
    logic             err;
  } entry_t;

  // One extra bit so a power-of-two Depth does not wrap to zero.
  localparam logic [Aw:0] DepthExt = (Aw+1)'(Depth);

  entry_t     mem [2];
  logic [1:0] count;
  logic [1:0] busy;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       inflight;
  logic       inflight_err;
  logic       out_of_range;
  logic       push;
  logic       pop;

  assign out_of_range  = {1'b0, host_addr_i} >= DepthExt;
  assign busy          = count + {1'b0, inflight};
  assign host_rvalid_o = (count != 2'd0);
  assign pop           = host_rvalid_o & host_rready_i;
  assign push          = inflight;

  // NOTE: a same-cycle pop frees a slot, so the grant may look at host_rready_i;
  // this is what lets a full buffer still sustain one grant per cycle.
  assign host_gnt_o    = host_req_i & ((busy < 2'd2) | pop);
  assign rom_req_o     = host_gnt_o & ~out_of_range;
  assign rom_addr_o    = host_addr_i;

  assign host_rdata_o  = mem[rd_ptr].data;
  assign host_rerr_o   = mem[rd_ptr].err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count        <= 2'd0;
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
    end else begin
      inflight     <= host_gnt_o;
      inflight_err <= host_gnt_o & out_of_range;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left unreset on purpose; clearing count and pointers is
  // enough to hide stale entries, and host_rdata_o is don't-care without rvalid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{data: (inflight_err ? '0 : rom_rdata_i), err: inflight_err};
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) count <= 2'd2);
  a_no_oor_fetch : assert property (@(posedge clk_i) disable iff (rst_i)
                                    rom_req_o |-> !out_of_range);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomised scoreboard bench for rom_fetch_ctrl: a request-order queue model
// predicts grants, response timing and data; a separate monitor checks pops.
module tb_rom_fetch_ctrl;

  localparam int Width = 32;
  localparam int Depth = 2000;
  localparam int Aw    = $clog2(Depth);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic [Aw-1:0]    addr = '0;
  logic             gnt;
  logic             rvalid;
  logic [Width-1:0] rdata;
  logic             rerr;
  logic             rready = 1'b1;
  logic             rom_req;
  logic [Aw-1:0]    rom_addr;
  logic [Width-1:0] rom_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int               cyc;
    logic [Width-1:0] data;
    logic             err;
  } exp_t;

  exp_t q[$];

  rom_fetch_ctrl #(.Width(Width), .Depth(Depth)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host_req_i    (req),
    .host_addr_i   (addr),
    .host_gnt_o    (gnt),
    .host_rvalid_o (rvalid),
    .host_rdata_o  (rdata),
    .host_rerr_o   (rerr),
    .host_rready_i (rready),
    .rom_req_o     (rom_req),
    .rom_addr_o    (rom_addr),
    .rom_rdata_i   (rom_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [Width-1:0] rom_fn(input logic [Aw-1:0] a);
    if (a == Aw'(16)) return 32'hDEAD_BEEF;
    return ({21'b0, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Registered ROM; returns noise when not strobed so stale data is exposed.
  always @(posedge clk) rom_rdata <= rom_req ? rom_fn(rom_addr) : $urandom();

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of stimulus and predict grant behaviour from the model:
  // at most two responses may be outstanding unless the head leaves this cycle.
  task automatic step(input logic r, input logic [Aw-1:0] a, input logic rr, input logic rs);
    logic head_ok;
    logic exp_gnt;
    exp_t e;
    @(negedge clk);
    req = r; addr = a; rready = rr; rst = rs;
    #1;
    if (rs) q.delete();
    head_ok = (q.size() != 0) && (q[0].cyc <= cyc - 2);
    exp_gnt = r && ((q.size() < 2) || (head_ok && rr));
    check("gnt", gnt, exp_gnt);
    check("rom_req", rom_req, exp_gnt && (a < Depth));
    check("rom_addr", rom_addr, a);
    if (exp_gnt) begin
      e.cyc  = cyc;
      e.err  = (a >= Depth);
      e.data = e.err ? '0 : rom_fn(a);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: a response is due two cycles after its grant once it reaches the head.
  initial begin : monitor
    exp_t e;
    logic exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        exp_v = (q.size() != 0) && (q[0].cyc <= cyc - 2);
        check("rvalid", rvalid, exp_v);
        if (exp_v && rready) begin
          e = q.pop_front();
          check("rdata", rdata, e.data);
          check("rerr", rerr, e.err);
        end
      end
    end
  end

  initial begin : driver
    logic r, rr, rs;
    logic [Aw-1:0] a;

    repeat (2) step(1'b0, '0, 1'b1, 1'b1);

    // Single read of the known word
    step(1'b1, Aw'(16), 1'b1, 1'b0);
    idle(4);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) step(1'b1, Aw'(i), 1'b1, 1'b0);
    idle(4);

    // Backpressure: fill, then a single pop with a same-cycle grant
    for (int i = 0; i < 5; i++) step(1'b1, Aw'(100 + i), 1'b0, 1'b0);
    step(1'b1, Aw'(200), 1'b1, 1'b0);
    repeat (3) step(1'b1, Aw'(201), 1'b0, 1'b0);
    idle(4);

    // Out-of-range reads interleaved with in-range ones
    step(1'b1, Aw'(5), 1'b1, 1'b0);
    step(1'b1, Aw'(2000), 1'b1, 1'b0);
    step(1'b1, Aw'(6), 1'b1, 1'b0);
    step(1'b1, Aw'(2047), 1'b1, 1'b0);
    step(1'b1, Aw'(1999), 1'b1, 1'b0);
    idle(4);

    // Reset while the buffer is full and work is outstanding
    step(1'b1, Aw'(300), 1'b0, 1'b0);
    step(1'b1, Aw'(301), 1'b0, 1'b0);
    step(1'b1, Aw'(302), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, Aw'(400), 1'b1, 1'b0);
    step(1'b1, Aw'(401), 1'b1, 1'b0);
    idle(4);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 99) == 0);
      r  = rs ? 1'b0 : ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 99) < 10) ? Aw'($urandom_range(2000, 2047))
                                         : Aw'($urandom_range(0, 1999));
      rr = ($urandom_range(0, 3) != 0);
      step(r, a, rr, rs);
    end

    idle(8);
    check("drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
